// File: rtl/router_input_buffer.sv
// -----------------------------------------------------------------------------
// router_input_buffer
//   Input-port stage of a mesh router. Single-flit packets are queued in a
//   DEPTH-entry FIFO. The head flit's destination is shown to the external
//   XY route-compute block. The select it returns is latched while the flit
//   moves into an output register. The flit then holds a one-hot request on
//   the selected output until the matching grant arrives.
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   in_valid_i   upstream flit valid
//   in_ready_o   upstream ready (buffer not full)
//   in_dst_x_i   destination x of incoming flit
//   in_dst_y_i   destination y of incoming flit
//   in_data_i    payload of incoming flit
//   rc_dst_x_o   head-entry dst_x to route compute
//   rc_dst_y_o   head-entry dst_y to route compute
//   rc_sel_i     route-compute select: 00 self, 01 NS, 10 WE, 11 diag
//   req_o        one-hot output request (bit = latched select)
//   gnt_i        per-output grant from the switch allocator
//   out_dst_x_o  registered dst_x of the flit being sent
//   out_dst_y_o  registered dst_y of the flit being sent
//   out_data_o   registered payload of the flit being sent
// -----------------------------------------------------------------------------
module router_input_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned maxx   = 2,
    parameter int unsigned maxy   = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [maxx-1:0]   in_dst_x_i,
    input  logic [maxy-1:0]   in_dst_y_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic [maxx-1:0]   rc_dst_x_o,
    output logic [maxy-1:0]   rc_dst_y_o,
    input  logic [1:0]        rc_sel_i,
    output logic [3:0]        req_o,
    input  logic [3:0]        gnt_i,
    output logic [maxx-1:0]   out_dst_x_o,
    output logic [maxy-1:0]   out_dst_y_o,
    output logic [DATA_W-1:0] out_data_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUTE = 2'd1,
        ST_SEND  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [maxx-1:0]   r_mem_x [DEPTH];
    logic [maxy-1:0]   r_mem_y [DEPTH];
    logic [DATA_W-1:0] r_mem_d [DEPTH];

    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [1:0]        r_sel;

    logic              w_push;
    logic              w_pop;
    logic              w_ready;

    // No bypass: a flit always spends at least one cycle in the FIFO.
    assign w_ready    = (r_count != CW'(DEPTH));
    assign in_ready_o = w_ready;
    assign w_push     = in_valid_i & w_ready;
    // ROUTE is only ever entered with a non-empty FIFO, so popping there is safe.
    assign w_pop      = (r_state == ST_ROUTE);

    assign rc_dst_x_o = r_mem_x[r_rd_ptr];
    assign rc_dst_y_o = r_mem_y[r_rd_ptr];

    // Storage needs no reset; validity is tracked by r_count.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem_x[r_wr_ptr] <= in_dst_x_i;
            r_mem_y[r_wr_ptr] <= in_dst_y_i;
            r_mem_d[r_wr_ptr] <= in_data_i;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_sel       <= 2'b00;
            out_dst_x_o <= '0;
            out_dst_y_o <= '0;
            out_data_o  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_ROUTE) begin
                r_sel       <= rc_sel_i;
                out_dst_x_o <= r_mem_x[r_rd_ptr];
                out_dst_y_o <= r_mem_y[r_rd_ptr];
                out_data_o  <= r_mem_d[r_rd_ptr];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_o       = '0;
        case (r_state)
            ST_IDLE: begin
                if (r_count != '0) w_state_nxt = ST_ROUTE;
            end
            ST_ROUTE: begin
                w_state_nxt = ST_SEND;
            end
            ST_SEND: begin
                req_o = 4'b0001 << r_sel;
                if (gnt_i[r_sel]) begin
                    w_state_nxt = (r_count != '0) ? ST_ROUTE : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_router_input_buffer.sv
// -----------------------------------------------------------------------------
// tb_router_input_buffer
//   Directed bench for router_input_buffer (DEPTH=4). A small XY route model
//   with self position (2,2) drives rc_sel_i from rc_dst_*_o.
// -----------------------------------------------------------------------------
module tb_router_input_buffer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_x;
    logic [1:0]  in_y;
    logic [31:0] in_data;
    logic [1:0]  rc_x;
    logic [1:0]  rc_y;
    logic [1:0]  rc_sel;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic [1:0]  out_x;
    logic [1:0]  out_y;
    logic [31:0] out_data;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    router_input_buffer #(
        .DEPTH  (4),
        .DATA_W (32),
        .maxx   (2),
        .maxy   (2)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_dst_x_i  (in_x),
        .in_dst_y_i  (in_y),
        .in_data_i   (in_data),
        .rc_dst_x_o  (rc_x),
        .rc_dst_y_o  (rc_y),
        .rc_sel_i    (rc_sel),
        .req_o       (req),
        .gnt_i       (gnt),
        .out_dst_x_o (out_x),
        .out_dst_y_o (out_y),
        .out_data_o  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External route compute, self at (2,2).
    always_comb begin
        rc_sel = 2'b00;
        if (rc_x != 2'd2 && rc_y != 2'd2) rc_sel = 2'b11;
        else if (rc_x != 2'd2)            rc_sel = 2'b10;
        else if (rc_y != 2'd2)            rc_sel = 2'b01;
    end

    // Wrap-test flit pattern: destination and the request it must produce.
    logic [1:0] tdx  [4] = '{2'd2, 2'd2, 2'd0, 2'd0};
    logic [1:0] tdy  [4] = '{2'd2, 2'd0, 2'd2, 2'd0};
    logic [3:0] treq [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a request, check it and the payload, optionally
    // stall the grant, then grant and check release.
    task automatic expect_flit(input string tag, input logic [3:0] exp_req,
                               input logic [31:0] exp_data, input int unsigned stall);
        int unsigned n = 0;
        while (req == 4'b0 && n < 50) begin
            tick();
            n++;
        end
        chk({tag, " req"}, req, exp_req);
        chk({tag, " data"}, out_data, exp_data);
        for (int unsigned s = 0; s < stall; s++) begin
            tick();
            chk({tag, " hold"}, req, exp_req);
        end
        gnt = exp_req;
        tick();
        gnt = 4'b0;
        chk({tag, " rel"}, req, 4'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  s_req  [9];
        logic [1:0]  sx     [3];
        logic [1:0]  sy     [3];
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_x     = '0;
        in_y     = '0;
        in_data  = '0;
        gnt      = '0;

        // ---- reset state
        #12;
        chk("rst req", req, 4'b0);
        chk("rst ready", in_ready, 1'b1);
        chk("rst data", out_data, 32'h0);
        chk("rst dst", {out_x, out_y}, 4'h0);
        #2 rst_n = 1'b1;
        tick();

        // ---- single flit to self
        in_valid = 1'b1; in_x = 2'd2; in_y = 2'd2; in_data = 32'hA5;
        tick();                                   // E0: accept
        in_valid = 1'b0;
        chk("single E0 req", req, 4'b0);
        tick();                                   // E1: -> ROUTE
        chk("single E1 req", req, 4'b0);
        tick();                                   // E2: -> SEND
        chk("single E2 req", req, 4'b0001);
        chk("single data", out_data, 32'hA5);
        chk("single dst", {out_x, out_y}, {2'd2, 2'd2});
        gnt = 4'b0001;
        tick();
        gnt = 4'b0;
        chk("single rel", req, 4'b0);
        tick();
        chk("single idle", req, 4'b0);

        // ---- reset while in SEND with req=0100
        in_valid = 1'b1; in_x = 2'd0; in_y = 2'd2; in_data = 32'h77;
        tick();
        in_x = 2'd2; in_y = 2'd2; in_data = 32'h78;
        tick();
        in_valid = 1'b0;
        tick();
        chk("rstm req before", req, 4'b0100);
        chk("rstm data before", out_data, 32'h77);
        #2 rst_n = 1'b0;
        #1;
        chk("rstm req async", req, 4'b0);
        chk("rstm ready", in_ready, 1'b1);
        chk("rstm data", out_data, 32'h0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("rstm quiet%0d", i), req, 4'b0);
        end

        // ---- fill: 5 accepted, 6th back-pressured
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_x = 2'd2; in_y = 2'd2; in_data = 32'h100 + i;
            chk($sformatf("fill ready%0d", i), in_ready, (i < 5) ? 1'b1 : 1'b0);
            if (i < 5) tick();
        end
        chk("fill req", req, 4'b0001);
        chk("fill head", out_data, 32'h100);
        gnt = 4'b0001;
        tick();
        gnt = 4'b0;
        chk("fill ready g+1", in_ready, 1'b0);
        tick();
        chk("fill ready g+2", in_ready, 1'b1);
        tick();                                   // 6th flit accepted
        in_valid = 1'b0;
        chk("fill ready full", in_ready, 1'b0);
        chk("fill next data", out_data, 32'h101);
        for (int i = 1; i < 6; i++)
            expect_flit($sformatf("drain%0d", i), 4'b0001, 32'h100 + i, 0);
        chk("drain ready", in_ready, 1'b1);

        // ---- wrong grant ignored
        in_valid = 1'b1; in_x = 2'd0; in_y = 2'd0; in_data = 32'h44;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("wgnt req", req, 4'b1000);
        gnt = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("wgnt hold%0d", i), req, 4'b1000);
        end
        gnt = 4'b1000;
        tick();
        gnt = 4'b0;
        chk("wgnt rel", req, 4'b0);
        tick();

        // ---- streaming with grant held (grant also present during IDLE/ROUTE)
        s_req = '{4'b0, 4'b0, 4'b0010, 4'b0, 4'b0100, 4'b0, 4'b0001, 4'b0, 4'b0};
        sx = '{2'd2, 2'd0, 2'd2};
        sy = '{2'd0, 2'd2, 2'd2};
        gnt = 4'b1111;
        for (int i = 0; i < 9; i++) begin
            in_valid = (i < 3);
            if (i < 3) begin
                in_x = sx[i]; in_y = sy[i]; in_data = 32'h500 + i;
            end
            tick();
            chk($sformatf("stream E%0d", i), req, s_req[i]);
            if (i == 2) chk("stream d0", out_data, 32'h500);
            if (i == 4) chk("stream d1", out_data, 32'h501);
            if (i == 6) chk("stream d2", out_data, 32'h502);
        end
        in_valid = 1'b0;
        gnt = 4'b0;

        // ---- pointer wrap with random stalls on both sides
        fork
            begin
                for (int i = 0; i < 11; i++) begin
                    int unsigned n;
                    logic acc;
                    in_valid = 1'b0;
                    repeat ($urandom_range(0, 2)) tick();
                    in_valid = 1'b1;
                    in_x = tdx[i % 4]; in_y = tdy[i % 4]; in_data = 32'h600 + i;
                    n = 0;
                    acc = 1'b0;
                    while (!acc && n < 50) begin
                        acc = in_ready;
                        tick();
                        n++;
                    end
                    if (!acc) chk($sformatf("wrap push%0d", i), acc, 1'b1);
                end
                in_valid = 1'b0;
            end
            begin
                for (int j = 0; j < 11; j++)
                    expect_flit($sformatf("wrap%0d", j), treq[j % 4], 32'h600 + j,
                                $urandom_range(0, 3));
            end
        join
        repeat (3) tick();
        chk("wrap end req", req, 4'b0);
        chk("wrap end ready", in_ready, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
